// File: rtl/rbm_batch_sequencer_pkg.sv
// Shared definitions for the RBM batch sequencer: score/port packing macros,
// FSM state encoding and a width helper. Optional feature macro used by the
// top: RBM_SEQ_TIMEOUT_EN (RUN-state watchdog).
`ifndef RBM_BATCH_SEQUENCER_DEFS
`define RBM_BATCH_SEQUENCER_DEFS
// Packed 1-D port of n elements, w bits each.
`define PORT_1D(n, w) [(n)*(w)-1:0]
// Element i of a packed 1-D vector of w-bit elements.
`define DIM_1D(i, w) (i)*(w) +: (w)
`endif

package rbm_batch_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CRST   = 3'd1,
        S_LOAD   = 3'd2,
        S_RUN    = 3'd3,
        S_SCAN   = 3'd4,
        S_REPORT = 3'd5,
        S_DONE   = 3'd6
    } seq_state_e;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rbm_batch_sequencer_argmax_scan.sv
// Serial signed argmax over OUTPUT_DIM packed scores, one element per cycle.
// start_i loads element 0; done_o pulses once the last element is compared.
// Strictly-greater replacement keeps the lowest index on ties.
module rbm_argmax_scan
    import rbm_batch_sequencer_pkg::*;
#(
    parameter int BITLENGTH  = 12,
    parameter int OUTPUT_DIM = 10,
    parameter int LABEL_W    = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                start_i,
    input  logic `PORT_1D(OUTPUT_DIM, BITLENGTH) scores_i,
    output logic                                done_o,
    output logic [LABEL_W-1:0]                  index_o,
    output logic signed [BITLENGTH-1:0]         max_o
);

    localparam int IW = clog2_min1(OUTPUT_DIM);

    logic [IW-1:0]               ptr_q;
    logic                        run_q;
    logic                        done_q;
    logic [LABEL_W-1:0]          idx_q;
    logic signed [BITLENGTH-1:0] max_q;
    logic signed [BITLENGTH-1:0] cur;

    assign cur     = scores_i[`DIM_1D(int'(ptr_q), BITLENGTH)];
    assign done_o  = done_q;
    assign index_o = idx_q;
    assign max_o   = max_q;

    // Walk the score vector, tracking the running maximum and its index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
            idx_q  <= '0;
            max_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                max_q  <= scores_i[`DIM_1D(0, BITLENGTH)];
                idx_q  <= '0;
                ptr_q  <= IW'(1);
                run_q  <= (OUTPUT_DIM > 1);
                done_q <= (OUTPUT_DIM == 1);
            end else if (run_q) begin
                if (cur > max_q) begin
                    max_q <= cur;
                    idx_q <= LABEL_W'(ptr_q);
                end
                if (int'(ptr_q) == OUTPUT_DIM - 1) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    ptr_q <= ptr_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rbm_batch_sequencer.sv
// Multi-image driver for the RBM core: loads each binarised image from the
// word loader, pulses core reset, runs the core, argmaxes the class scores
// and reports per-image results plus running accuracy counts.
// Optional feature: define RBM_SEQ_TIMEOUT_EN to enable the RUN watchdog.
module rbm_batch_sequencer
    import rbm_batch_sequencer_pkg::*;
#(
    parameter int NUM_IMAGES     = 100,
    parameter int INPUT_DIM      = 784,
    parameter int OUTPUT_DIM     = 10,
    parameter int BITLENGTH      = 12,
    parameter int WORD_W         = 32,
    parameter int LABEL_W        = 4,
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int CW            = $clog2(NUM_IMAGES + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 start_i,
    input  logic                                 img_valid_i,
    output logic                                 img_ready_o,
    input  logic [WORD_W-1:0]                    img_word_i,
    input  logic [LABEL_W-1:0]                   img_label_i,
    output logic                                 core_reset_o,
    output logic                                 core_data_valid_o,
    output logic [INPUT_DIM-1:0]                 core_input_o,
    input  logic                                 core_finish_i,
    input  logic `PORT_1D(OUTPUT_DIM, BITLENGTH)  core_output_i,
    output logic                                 res_valid_o,
    input  logic                                 res_ready_i,
    output logic [LABEL_W-1:0]                   res_class_o,
    output logic                                 res_correct_o,
    output logic                                 res_timeout_o,
    output logic [CW-1:0]                        correct_count_o,
    output logic [CW-1:0]                        image_count_o,
    output logic                                 busy_o,
    output logic                                 batch_done_o
);

    localparam int WORDS = (INPUT_DIM + WORD_W - 1) / WORD_W;
    localparam int WCW   = clog2_min1(WORDS);
    localparam int RCW   = clog2_min1(RST_CYCLES);

    seq_state_e                        state_q;
    logic [RCW-1:0]                    rcnt_q;
    logic [WCW-1:0]                    wcnt_q;
    logic [LABEL_W-1:0]                label_q;
    logic                              img_ready_q;
    logic                              core_reset_q;
    logic                              dv_q;
    logic [INPUT_DIM-1:0]              core_input_q;
    logic                              fin_q, fin_qq;
    logic `PORT_1D(OUTPUT_DIM, BITLENGTH) scores_q;
    logic                              scan_start_q;
    logic                              res_valid_q;
    logic [LABEL_W-1:0]                res_class_q;
    logic                              res_correct_q;
    logic [CW-1:0]                     img_cnt_q;
    logic [CW-1:0]                     cor_cnt_q;
    logic                              batch_done_q;
    logic                              scan_done;
    logic [LABEL_W-1:0]                scan_idx;
    logic                              fin_rise;
    logic                              load_hs;

    assign fin_rise = fin_q & ~fin_qq;
    assign load_hs  = (state_q == S_LOAD) & img_ready_q & img_valid_i;

    rbm_argmax_scan #(
        .BITLENGTH (BITLENGTH),
        .OUTPUT_DIM(OUTPUT_DIM),
        .LABEL_W   (LABEL_W)
    ) u_scan (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (scan_start_q),
        .scores_i(scores_q),
        .done_o  (scan_done),
        .index_o (scan_idx),
        .max_o   ()
    );

`ifdef RBM_SEQ_TIMEOUT_EN
    localparam int TW = clog2_min1(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_q;
    logic          res_timeout_q;
    assign res_timeout_o = res_timeout_q;
`else
    assign res_timeout_o = 1'b0;
`endif

    // Register core_finish so the rise is seen on a clean, registered edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fin_q  <= 1'b0;
            fin_qq <= 1'b0;
        end else begin
            fin_q  <= core_finish_i;
            fin_qq <= fin_q;
        end
    end

    // Drop each accepted word into its slot; bits past INPUT_DIM are discarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            core_input_q <= '0;
        end else if (load_hs) begin
            for (int i = 0; i < INPUT_DIM; i++) begin
                if (i / WORD_W == int'(wcnt_q)) core_input_q[i] <= img_word_i[i % WORD_W];
            end
        end
    end

    // Batch control FSM with registered outputs and counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            rcnt_q        <= '0;
            wcnt_q        <= '0;
            label_q       <= '0;
            img_ready_q   <= 1'b0;
            core_reset_q  <= 1'b0;
            dv_q          <= 1'b0;
            scores_q      <= '0;
            scan_start_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            res_class_q   <= '0;
            res_correct_q <= 1'b0;
            img_cnt_q     <= '0;
            cor_cnt_q     <= '0;
            batch_done_q  <= 1'b0;
`ifdef RBM_SEQ_TIMEOUT_EN
            tmo_q         <= '0;
            res_timeout_q <= 1'b0;
`endif
        end else begin
            scan_start_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q      <= S_CRST;
                        core_reset_q <= 1'b1;
                        rcnt_q       <= '0;
                        img_cnt_q    <= '0;
                        cor_cnt_q    <= '0;
                        batch_done_q <= 1'b0;
                    end
                end
                S_CRST: begin
                    if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
                        state_q      <= S_LOAD;
                        core_reset_q <= 1'b0;
                        img_ready_q  <= 1'b1;
                        wcnt_q       <= '0;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (load_hs) begin
                        if (wcnt_q == '0) label_q <= img_label_i;
                        if (wcnt_q == WCW'(WORDS - 1)) begin
                            state_q     <= S_RUN;
                            img_ready_q <= 1'b0;
                            dv_q        <= 1'b1;
`ifdef RBM_SEQ_TIMEOUT_EN
                            tmo_q       <= '0;
`endif
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (fin_rise) begin
                        state_q      <= S_SCAN;
                        dv_q         <= 1'b0;
                        scores_q     <= core_output_i;
                        scan_start_q <= 1'b1;
                    end
`ifdef RBM_SEQ_TIMEOUT_EN
                    else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        // Watchdog: report a forced miss and move on.
                        state_q       <= S_REPORT;
                        dv_q          <= 1'b0;
                        res_valid_q   <= 1'b1;
                        res_class_q   <= '1;
                        res_correct_q <= 1'b0;
                        res_timeout_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                S_SCAN: begin
                    if (scan_done) begin
                        state_q       <= S_REPORT;
                        res_valid_q   <= 1'b1;
                        res_class_q   <= scan_idx;
                        res_correct_q <= (scan_idx == label_q);
`ifdef RBM_SEQ_TIMEOUT_EN
                        res_timeout_q <= 1'b0;
`endif
                    end
                end
                S_REPORT: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        img_cnt_q   <= img_cnt_q + 1'b1;
                        if (res_correct_q) cor_cnt_q <= cor_cnt_q + 1'b1;
                        if (img_cnt_q == CW'(NUM_IMAGES - 1)) begin
                            state_q      <= S_DONE;
                            batch_done_q <= 1'b1;
                        end else begin
                            state_q      <= S_CRST;
                            core_reset_q <= 1'b1;
                            rcnt_q       <= '0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign img_ready_o       = img_ready_q;
    assign core_reset_o      = core_reset_q;
    assign core_data_valid_o = dv_q;
    assign core_input_o      = core_input_q;
    assign res_valid_o       = res_valid_q;
    assign res_class_o       = res_class_q;
    assign res_correct_o     = res_correct_q;
    assign correct_count_o   = cor_cnt_q;
    assign image_count_o     = img_cnt_q;
    assign busy_o            = !(state_q inside {S_IDLE, S_DONE});
    assign batch_done_o      = batch_done_q;

endmodule
